// File: rtl/stack_pkg.sv
// Shared widths, defaults and arbiter state encoding
// for the operating_unit stack processor slice.
package stack_pkg;

  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_ABORT,
    S_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins,
// a tie goes to the requester named by prio_i.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] win_o
);

  // one-hot winner, or zero when nobody asks
  always_comb begin
    win_o = req_i;
    if (req_i == 2'b11) begin
      win_o = prio_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/op_unit_arbiter.sv
// Shares one operating_unit core between two hosts:
// grant, program load, run handshake, watchdog abort.
module op_unit_arbiter
  import stack_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [1:0]             req,
  input  logic [1:0]             go,
  input  logic [1:0]             wr,
  input  logic [1:0][ADDR_W-1:0] addr,
  input  logic [1:0][DATA_W-1:0] datain,
  output logic [1:0]             grant,
  output logic [1:0]             done,
  output logic [1:0]             err,
  output logic [DATA_W-1:0]      result,
  output logic                   core_wr,
  output logic                   core_start,
  output logic [ADDR_W-1:0]      core_addr,
  output logic [DATA_W-1:0]      core_data,
  output logic                   core_nrst,
  input  logic                   core_ready,
  input  logic [DATA_W-1:0]      core_out
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              prio_q, prio_d;
  logic              abrt_q, abrt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        win;
  logic              g;
  logic              abort;

  assign g = grant_q[1];

  rr_arbiter2 u_rr (
    .req_i  (req),
    .prio_i (prio_q),
    .win_o  (win)
  );

  // session sequencing: grant, load, start, run, finish
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    prio_d   = prio_q;
    abrt_d   = abrt_q;
    result_d = result_q;
    timer_d  = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_d = win;
          prio_d  = win[0];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!req[g]) begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else if (go[g]) begin
          abrt_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!core_ready) begin
          timer_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        timer_d = timer_q + 1'b1;
        if (core_ready) begin
          result_d = core_out;
          state_d  = S_DONE;
        end else if (timer_d == TMAX) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        result_d = '0;
        abrt_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (req[g]) begin
          state_d = S_LOAD;
        end else begin
          grant_d = 2'b00;
          state_d = S_IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  // core-side muxing and host-side pulses
  always_comb begin
    abort      = (state_q == S_ABORT);
    core_nrst  = nrst & ~abort;
    core_start = (state_q == S_START);
    core_wr    = 1'b0;
    core_addr  = '0;
    core_data  = '0;
    if (state_q == S_LOAD) begin
      core_wr   = wr[g];
      core_addr = addr[g];
      core_data = datain[g];
    end
    done   = (state_q == S_DONE) ? grant_q : 2'b00;
    err    = done & {2{abrt_q}};
    grant  = grant_q;
    result = result_q;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      prio_q   <= 1'b0;
      abrt_q   <= 1'b0;
      result_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      abrt_q   <= abrt_d;
      result_q <= result_d;
      timer_q  <= timer_d;
    end
  end

endmodule

// File: tb/tb_op_unit_arbiter.sv
// Bench for op_unit_arbiter with a tiny stack-core stand-in
// and a round-robin reference model.
module tb_op_unit_arbiter;
  import stack_pkg::*;

  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic [1:0]        req, go, wr;
  logic [1:0][9:0]   addr;
  logic [1:0][15:0]  datain;
  logic [1:0]        grant, done, err;
  logic [15:0]       result;
  logic              core_wr, core_start, core_nrst;
  logic [9:0]        core_addr;
  logic [15:0]       core_data;
  logic              core_ready;
  logic [15:0]       core_out;

  int   checks = 0;
  int   errors = 0;
  logic m_prio;

  always #5 clk = ~clk;

  op_unit_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .req        (req),
    .go         (go),
    .wr         (wr),
    .addr       (addr),
    .datain     (datain),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .result     (result),
    .core_wr    (core_wr),
    .core_start (core_start),
    .core_addr  (core_addr),
    .core_data  (core_data),
    .core_nrst  (core_nrst),
    .core_ready (core_ready),
    .core_out   (core_out)
  );

  // core stand-in: 00=push imm, 01=jump, 10=add, 11=halt
  logic [15:0] cmem [1024];
  logic [15:0] stk [16];
  logic [3:0]  sp;
  logic [9:0]  pc;
  logic        running;
  logic [15:0] ins;

  assign ins = cmem[pc];

  always @(posedge clk) begin
    if (core_wr) cmem[core_addr] <= core_data;
  end

  always @(posedge clk) begin
    if (!core_nrst) begin
      core_ready <= 1'b1;
      running    <= 1'b0;
      pc         <= '0;
      sp         <= '0;
      core_out   <= '0;
    end else if (core_ready && core_start) begin
      core_ready <= 1'b0;
      running    <= 1'b1;
      pc         <= '0;
      sp         <= '0;
    end else if (running) begin
      case (ins[15:14])
        2'b00: begin
          stk[sp] <= {2'b00, ins[13:0]};
          sp      <= sp + 4'd1;
          pc      <= pc + 10'd1;
        end
        2'b01: pc <= ins[9:0];
        2'b10: begin
          stk[sp-4'd2] <= stk[sp-4'd2] + stk[sp-4'd1];
          sp           <= sp - 4'd1;
          pc           <= pc + 10'd1;
        end
        default: begin
          core_out   <= stk[sp-4'd1];
          core_ready <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

  // reference: tie goes to m_prio, winner hands priority over
  function automatic logic [1:0] pick(input logic [1:0] r);
    logic w;
    w = (r == 2'b11) ? m_prio : r[1];
    m_prio = ~w;
    return w ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_add(input int w, input logic [13:0] a,
                          input logic [13:0] b);
    logic [15:0] p [4];
    p[0] = {2'b00, a};
    p[1] = {2'b00, b};
    p[2] = 16'h8002;
    p[3] = 16'hC000;
    for (int i = 0; i < 4; i++) begin
      wr[w]       = 1'b1;
      addr[w]     = 10'(i);
      datain[w]   = p[i];
      wr[1-w]     = 1'b1;
      addr[1-w]   = 10'(i);
      datain[1-w] = 16'h4000;
      step();
    end
    wr = 2'b00;
  endtask

  task automatic fire(input int w);
    go[w] = 1'b1;
    step();
    go = 2'b00;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    req = 2'b11;
    go = 2'b00;
    wr = 2'b00;
    addr = '0;
    datain = '0;
    repeat (3) step();
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || err !== 2'b00) begin
      errors++;
      $display("FAIL rst_hs got g=%b d=%b e=%b want 0",
               grant, done, err);
    end
    checks++;
    if (result !== 16'h0 || core_start !== 1'b0 ||
        core_wr !== 1'b0 || core_nrst !== 1'b0) begin
      errors++;
      $display("FAIL rst_core got r=%h s=%b w=%b n=%b want 0",
               result, core_start, core_wr, core_nrst);
    end
    nrst = 1'b1;
    m_prio = 1'b0;
    step();
    begin
      logic [1:0] e;
      e = pick(2'b11);
      checks++;
      if (grant !== e) begin
        errors++;
        $display("FAIL first_grant got %b want %b", grant, e);
      end
      req = 2'b00;
      step();
      checks++;
      if (grant !== 2'b00) begin
        errors++;
        $display("FAIL release got %b want 00", grant);
      end
      req = 2'b11;
      step();
      e = pick(2'b11);
      checks++;
      if (grant !== e) begin
        errors++;
        $display("FAIL second_grant got %b want %b", grant, e);
      end
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_basic_run();
    logic [13:0] a, b;
    logic [1:0]  e;
    bit          ok;
    a = 14'($urandom_range(0, 8191));
    b = 14'($urandom_range(0, 8191));
    req = 2'b11;
    step();
    e = pick(2'b11);
    checks++;
    if (grant !== e) begin
      errors++;
      $display("FAIL basic_grant got %b want %b", grant, e);
    end
    wr[0] = 1'b1;
    addr[0] = 10'd0;
    datain[0] = {2'b00, a};
    wr[1] = 1'b1;
    addr[1] = 10'd9;
    datain[1] = 16'h4000;
    #1;
    checks++;
    if (core_wr !== 1'b1 || core_addr !== 10'd0 ||
        core_data !== {2'b00, a}) begin
      errors++;
      $display("FAIL mux got w=%b a=%h d=%h want 1 0 %h",
               core_wr, core_addr, core_data, {2'b00, a});
    end
    wr[0] = 1'b0;
    #1;
    checks++;
    if (core_wr !== 1'b0) begin
      errors++;
      $display("FAIL other_wr got %b want 0", core_wr);
    end
    wr = 2'b00;
    load_add(0, a, b);
    for (int k = 0; k < 2; k++) begin
      go[1] = 1'b1;
      fire(0);
      checks++;
      if (core_start !== 1'b1) begin
        errors++;
        $display("FAIL start got %b want 1", core_start);
      end
      wait_done(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL basic_timeout got none want done");
      end
      checks++;
      if (done !== 2'b01 || err !== 2'b00 ||
          result !== 16'(a) + 16'(b)) begin
        errors++;
        $display("FAIL basic_res got d=%b e=%b r=%h want 01 00 %h",
                 done, err, result, 16'(a) + 16'(b));
      end
      step();
      checks++;
      if (done !== 2'b00 || grant !== 2'b01) begin
        errors++;
        $display("FAIL after_done got d=%b g=%b want 00 01",
                 done, grant);
      end
    end
    req = 2'b10;
    step();
    step();
    e = pick(2'b10);
    checks++;
    if (grant !== e) begin
      errors++;
      $display("FAIL handover got %b want %b", grant, e);
    end
    req = 2'b00;
    step();
    step();
  endtask

  task automatic test_random_sessions();
    logic [13:0] a, b;
    logic [1:0]  r, e;
    bit          ok;
    int          w;
    for (int k = 0; k < 8; k++) begin
      a = 14'($urandom_range(0, 16383));
      b = 14'($urandom_range(0, 16383));
      r = 2'($urandom_range(1, 3));
      req = r;
      step();
      e = pick(r);
      checks++;
      if (grant !== e) begin
        errors++;
        $display("FAIL rnd_grant k=%0d got %b want %b", k, grant, e);
      end
      w = e[1] ? 1 : 0;
      load_add(w, a, b);
      repeat ($urandom_range(0, 3)) step();
      fire(w);
      wait_done(ok);
      checks++;
      if (!ok || done !== e || err !== 2'b00 ||
          result !== 16'(a) + 16'(b)) begin
        errors++;
        $display("FAIL rnd_run k=%0d got d=%b e=%b r=%h want %b 00 %h",
                 k, done, err, result, e, 16'(a) + 16'(b));
      end
      req = 2'b00;
      step();
      step();
    end
  endtask

  task automatic test_watchdog();
    logic [1:0] e;
    int         n, cyc;
    req = 2'b01;
    step();
    e = pick(2'b01);
    checks++;
    if (grant !== e) begin
      errors++;
      $display("FAIL wd_grant got %b want %b", grant, e);
    end
    wr[0] = 1'b1;
    addr[0] = 10'd0;
    datain[0] = 16'h4000;
    step();
    wr = 2'b00;
    fire(0);
    n = 0;
    while (core_start && n < 50) begin
      step();
      n++;
    end
    cyc = 0;
    while (core_nrst && cyc < 100) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != TO) begin
      errors++;
      $display("FAIL wd_cycles got %0d want %0d", cyc, TO);
    end
    step();
    checks++;
    if (done !== 2'b01 || err !== 2'b01 || result !== 16'h0) begin
      errors++;
      $display("FAIL wd_done got d=%b e=%b r=%h want 01 01 0",
               done, err, result);
    end
    step();
    checks++;
    if (done !== 2'b00 || err !== 2'b00) begin
      errors++;
      $display("FAIL wd_pulse got d=%b e=%b want 00 00", done, err);
    end
  endtask

  task automatic test_reset_midrun();
    logic [1:0] e;
    fire(0);
    repeat (5) step();
    nrst = 1'b0;
    step();
    checks++;
    if (grant !== 2'b00 || core_nrst !== 1'b0 || done !== 2'b00) begin
      errors++;
      $display("FAIL midrst got g=%b n=%b d=%b want 00 0 00",
               grant, core_nrst, done);
    end
    nrst = 1'b1;
    m_prio = 1'b0;
    step();
    e = pick(2'b01);
    checks++;
    if (grant !== e || done !== 2'b00) begin
      errors++;
      $display("FAIL regrant got g=%b d=%b want %b 00", grant, done, e);
    end
  endtask

  task automatic test_go_drop();
    go[0] = 1'b1;
    req = 2'b00;
    step();
    go = 2'b00;
    checks++;
    if (core_start !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL go_drop got s=%b g=%b want 0 00",
               core_start, grant);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_random_sessions();
    test_watchdog();
    test_reset_midrun();
    test_go_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
